// File: rtl/arb_pkg.sv
// Shared definitions for the sram-like port arbiter: FSM states, source ids
// recorded in the response-order FIFO, and sram-like transfer size codes.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } arb_state_e;

    // Source id pushed per accepted address phase
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // sram-like size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/req_order_fifo.sv
// DEPTH x 1-bit in-order FIFO holding the source id of every accepted
// transaction so responses are routed back to the requester that issued them.
// The head is read combinationally because the response routing is same-cycle.
module req_order_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] slot_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slot_reg[rd_ptr_reg];

    // One register per slot; only the slot under the write pointer captures
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    slot_reg[gi] <= SRC_INST;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    slot_reg[gi] <= push_id;
                end
            end
        end
    endgenerate

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and count registers; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-to-one arbiter sharing one sram-like memory port between the
// instruction-fetch and data requesters. Data has priority except when inst
// has been starved for STARVE_MAX consecutive data accepts. A grant stays
// locked to its requester until the address phase is accepted or withdrawn.
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction requester
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // downstream memory port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);

    arb_state_e    state_reg;
    arb_state_e    state_next;
    logic [SW-1:0] starve_cnt_reg;
    logic [SW-1:0] starve_cnt_next;

    logic sel_data;
    logic win_req;
    logic accept;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;
    logic resp_valid;

    // Grant selection: free choice in IDLE, fixed while locked
    always_comb begin
        sel_data = 1'b0;
        case (state_reg)
            IDLE:    sel_data = data_req & ~(inst_req & (starve_cnt_reg == STARVE_CAP));
            LOCK_I:  sel_data = 1'b0;
            LOCK_D:  sel_data = 1'b1;
            default: sel_data = 1'b0;
        endcase
    end

    assign win_req = sel_data ? data_req : inst_req;

    // A full order FIFO blocks all grants so no accept can overflow it
    assign mem_req   = win_req & ~fifo_full;
    assign mem_wr    = sel_data ? data_wr    : inst_wr;
    assign mem_size  = sel_data ? data_size  : inst_size;
    assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = sel_data ? data_addr  : inst_addr;
    assign mem_wdata = sel_data ? data_wdata : inst_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~sel_data;
    assign data_addr_ok = accept &  sel_data;

    // Responses return in order; a data_ok with nothing outstanding is dropped
    assign resp_valid   = mem_data_ok & ~fifo_empty;
    assign inst_data_ok = resp_valid & (fifo_head == SRC_INST);
    assign data_data_ok = resp_valid & (fifo_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Next-state: lock on a stalled grant, release on accept or withdrawal
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_next = sel_data ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I: begin
                if (!inst_req || mem_addr_ok) state_next = IDLE;
            end
            LOCK_D: begin
                if (!data_req || mem_addr_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Starvation counter: counts data accepts that bypass a waiting inst
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!inst_req || inst_addr_ok) begin
            starve_cnt_next = '0;
        end else if (data_addr_ok && (starve_cnt_reg != STARVE_CAP)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    // State and starvation registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    req_order_fifo #(
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (sel_data ? SRC_DATA : SRC_INST),
        .pop     (mem_data_ok),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: the expected source of every
// address phase the bench expects to be accepted is queued, and each
// mem_data_ok pops the queue to predict which requester gets the response.
module tb_sram_port_arbiter;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    // Check the response routing of a settled mem_data_ok cycle
    task automatic check_resp(input string tag);
        logic src;
        if (exp_q.size() == 0) begin
            chk({tag, "_iok_none"}, 32'(inst_data_ok), 32'd0);
            chk({tag, "_dok_none"}, 32'(data_data_ok), 32'd0);
            $display("resp %s: none outstanding", tag);
        end else begin
            src = exp_q.pop_front();
            chk({tag, "_iok"}, 32'(inst_data_ok), 32'(src == SRC_INST));
            chk({tag, "_dok"}, 32'(data_data_ok), 32'(src == SRC_DATA));
            chk({tag, "_rdata"}, (src == SRC_INST) ? inst_rdata : data_rdata, mem_rdata);
            $display("resp %s: src=%0d rdata=%h", tag, src, mem_rdata);
        end
    endtask

    task automatic respond(input logic [31:0] rd, input string tag);
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        #1;
        check_resp(tag);
        step();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [6];
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        resetn = 1'b0;
        idle_inputs();
        mem_data_ok = 1'b1;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_iok", 32'(inst_data_ok), 32'd0);
        chk("rst_dok", 32'(data_data_ok), 32'd0);
        chk("rst_iaok", 32'(inst_addr_ok), 32'd0);
        mem_data_ok = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();

        // ---------------- single inst read ----------------
        inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
        #1;
        chk("single_mem_req", 32'(mem_req), 32'd1);
        chk("single_mem_addr", mem_addr, 32'h1c00_0000);
        chk("single_iaok", 32'(inst_addr_ok), 32'd1);
        chk("single_daok", 32'(data_addr_ok), 32'd0);
        exp_q.push_back(SRC_INST);
        $display("req single: inst addr=1c000000 accepted");
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        step();
        step();
        respond(32'h1234_5678, "single");

        // ---------------- simultaneous requests ----------------
        inst_req = 1'b1; inst_addr = 32'h0000_0100;
        data_req = 1'b1; data_addr = 32'h0000_0080; data_wr = 1'b1; data_wstrb = 4'hF;
        data_wdata = 32'hCAFE_F00D; mem_addr_ok = 1'b1;
        #1;
        chk("simul_mem_addr", mem_addr, 32'h80);
        chk("simul_mem_wr", 32'(mem_wr), 32'd1);
        chk("simul_mem_wstrb", 32'(mem_wstrb), 32'hF);
        chk("simul_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        chk("simul_daok", 32'(data_addr_ok), 32'd1);
        chk("simul_iaok", 32'(inst_addr_ok), 32'd0);
        exp_q.push_back(SRC_DATA);
        $display("req simul: data addr=80 accepted");
        step();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        #1;
        chk("simul2_iaok", 32'(inst_addr_ok), 32'd1);
        chk("simul2_mem_addr", mem_addr, 32'h100);
        exp_q.push_back(SRC_INST);
        $display("req simul: inst addr=100 accepted");
        step();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        respond(32'hD000_0001, "simul_d");
        respond(32'hD000_0002, "simul_i");

        // ---------------- lock ----------------
        inst_req = 1'b1; inst_addr = 32'h0000_0200; mem_addr_ok = 1'b0;
        #1;
        chk("lock1_mem_req", 32'(mem_req), 32'd1);
        chk("lock1_mem_addr", mem_addr, 32'h200);
        chk("lock1_iaok", 32'(inst_addr_ok), 32'd0);
        step();
        data_req = 1'b1; data_addr = 32'h0000_0084;
        #1;
        chk("lock2_mem_addr", mem_addr, 32'h200);
        chk("lock2_daok", 32'(data_addr_ok), 32'd0);
        step();
        #1;
        chk("lock3_mem_addr", mem_addr, 32'h200);
        step();
        mem_addr_ok = 1'b1;
        #1;
        chk("lock4_iaok", 32'(inst_addr_ok), 32'd1);
        chk("lock4_daok", 32'(data_addr_ok), 32'd0);
        chk("lock4_mem_addr", mem_addr, 32'h200);
        exp_q.push_back(SRC_INST);
        $display("req lock: inst addr=200 accepted");
        step();
        inst_req = 1'b0;
        #1;
        chk("lock5_daok", 32'(data_addr_ok), 32'd1);
        chk("lock5_mem_addr", mem_addr, 32'h84);
        exp_q.push_back(SRC_DATA);
        $display("req lock: data addr=84 accepted");
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        respond(32'hB000_0001, "lock_i");
        respond(32'hB000_0002, "lock_d");

        // ---------------- starvation ----------------
        inst_req = 1'b1; inst_addr = 32'h0000_0300;
        data_req = 1'b1; data_addr = 32'h0000_0090;
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_data_ok = (i > 0);
            mem_rdata   = 32'hA000_0000 + 32'(i);
            #1;
            if (i > 0) check_resp("starve_rsp");
            chk("starve_daok", 32'(data_addr_ok), 32'(pat[i]));
            chk("starve_iaok", 32'(inst_addr_ok), 32'(!pat[i]));
            chk("starve_mem_addr", mem_addr, pat[i] ? 32'h90 : 32'h300);
            exp_q.push_back(pat[i] ? SRC_DATA : SRC_INST);
            $display("req starve %0d: expect %s", i, pat[i] ? "data" : "inst");
            step();
        end
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        respond(32'hA000_0006, "starve_last");

        // ---------------- FIFO full ----------------
        inst_req = 1'b1; inst_addr = 32'h0000_0400; mem_addr_ok = 1'b1;
        #1;
        chk("full_iaok0", 32'(inst_addr_ok), 32'd1);
        exp_q.push_back(SRC_INST);
        $display("req full: inst addr=400 accepted");
        step();
        data_req = 1'b1; data_addr = 32'h0000_00A0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_fill_daok", 32'(data_addr_ok), 32'd1);
            exp_q.push_back(SRC_DATA);
            $display("req full: data fill %0d accepted", i);
            step();
        end
        #1;
        chk("full_mem_req", 32'(mem_req), 32'd0);
        chk("full_iaok", 32'(inst_addr_ok), 32'd0);
        chk("full_daok", 32'(data_addr_ok), 32'd0);
        step();
        mem_data_ok = 1'b1; mem_rdata = 32'hF00D_0001;
        #1;
        chk("full_pop_mem_req", 32'(mem_req), 32'd0);
        check_resp("full_pop");
        step();
        mem_data_ok = 1'b0;
        #1;
        chk("full_resume_mem_req", 32'(mem_req), 32'd1);
        chk("full_resume_daok", 32'(data_addr_ok), 32'd1);
        exp_q.push_back(SRC_DATA);
        $display("req full: data resume accepted");
        step();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) respond(32'hF00D_0010 + 32'(i), "full_drain");

        // ---------------- reset mid-flight ----------------
        inst_req = 1'b1; inst_addr = 32'h0000_0500; mem_addr_ok = 1'b1;
        #1;
        chk("rmf_iaok", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_00B0;
        #1;
        chk("rmf_daok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        #3;
        resetn = 1'b0;
        exp_q.delete();
        $display("reset asserted mid-flight with 2 outstanding");
        #1;
        mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rmf_hold_iok", 32'(inst_data_ok), 32'd0);
        chk("rmf_hold_dok", 32'(data_data_ok), 32'd0);
        step();
        resetn = 1'b1;
        #1;
        check_resp("rmf_after");
        step();
        mem_data_ok = 1'b0;

        // FIFO must behave from empty after the flush
        data_req = 1'b1; data_addr = 32'h0000_00C0; mem_addr_ok = 1'b1;
        #1;
        chk("post_rst_daok", 32'(data_addr_ok), 32'd1);
        exp_q.push_back(SRC_DATA);
        step();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        respond(32'h5555_AAAA, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-to-one arbiter that shares the single sram-like memory port (cache / AXI bridge side) between the instruction-fetch requester and the execute-stage data requester. It grants address phases, locks the grant until `addr_ok`, and records the source of every accepted transaction in an in-order FIFO so each `data_ok` / `rdata` returns to the right requester. It sits between the pipeline's `inst_sram_*` / `data_sram_*` interfaces and the downstream memory port.

## Interface
Parameters:
- `DEPTH`, 4 — maximum outstanding accepted-but-unanswered transactions; power of two, at least 2.
- `STARVE_MAX`, 4 — consecutive data grants allowed while inst is waiting before inst is forced through.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `inst_req`, `inst_wr`  in  1  instruction requester address phase.
- `inst_size`  in  2  instruction request size.
- `inst_wstrb`  in  4  instruction write strobes.
- `inst_addr`, `inst_wdata`  in  32  instruction address and write data.
- `inst_addr_ok`, `inst_data_ok`  out  1  instruction handshakes.
- `inst_rdata`  out  32  instruction read data.
- `data_req`, `data_wr`  in  1  data requester address phase.
- `data_size`  in  2  data request size.
- `data_wstrb`  in  4  data write strobes.
- `data_addr`, `data_wdata`  in  32  data address and write data.
- `data_addr_ok`, `data_data_ok`  out  1  data handshakes.
- `data_rdata`  out  32  data read data.
- `mem_req`, `mem_wr`  out  1  downstream address phase.
- `mem_size`  out  2  downstream request size.
- `mem_wstrb`  out  4  downstream write strobes.
- `mem_addr`, `mem_wdata`  out  32  downstream address and write data.
- `mem_addr_ok`, `mem_data_ok`  in  1  downstream handshakes.
- `mem_rdata`  in  32  downstream read data.

## Operation
- States: IDLE, LOCK_I, LOCK_D.
- IDLE: pick the grant combinationally from the current requests.
  - Data wins over inst.
  - Exception: inst wins when `starve_cnt == STARVE_MAX` and `inst_req` is asserted.
  - `mem_*` payload is muxed from the winner.
  - If the winner requests and `mem_addr_ok` is low, go to LOCK_x for that requester.
- LOCK_x: grant is fixed to x; the other requester is not selected.
  - On `x_req & mem_addr_ok`, return to IDLE.
  - If `x_req` deasserts (withdrawn request), return to IDLE next cycle; `mem_req` follows `x_req` directly and never fakes a request.
- Accept = `mem_req & mem_addr_ok`. Accept asserts the granted `x_addr_ok` in the same cycle and pushes the source id (0 = inst, 1 = data) into the order FIFO.
- FIFO full: `mem_req` is forced to 0 and no grant is issued. Full is computed from the registered count, so there is no same-cycle push while full.
- `mem_data_ok` with FIFO non-empty:
  - Pop the head.
  - Assert `inst_data_ok` or `data_data_ok` according to the head id.
  - `mem_rdata` is broadcast to both `*_rdata`.
- `mem_data_ok` with FIFO empty: protocol error; ignored, no requester-side `data_ok`.
- Push and pop in the same cycle: count unchanged; allowed at any fill level below full.
- Starvation counter `starve_cnt`:
  - Increment on a data accept while `inst_req` is high, saturating at `STARVE_MAX`.
  - Clear on an inst accept, or when `inst_req` is low.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.

## Timing
- Request path is combinational: `x_req` to `mem_req`, and `mem_addr_ok` to `x_addr_ok`, in the same cycle. Zero added latency.
- Response path is combinational: `mem_data_ok` to `x_data_ok` in the same cycle.
- Lock, FIFO and starvation state update on the clock edge after the triggering event.
- Reset values (`resetn` low, asynchronous):
  - State IDLE, FIFO empty, pointers 0, `starve_cnt` 0.
  - All outputs 0 given inactive inputs.
  - `*_data_ok` are 0 regardless of `mem_data_ok`.
- Reset mid-operation: outstanding entries are discarded. Any `mem_data_ok` arriving after reset is ignored. The upstream reset flushes requesters consistently.

## Structure
- Shared package `arb_pkg`:
  - State encoding IDLE / LOCK_I / LOCK_D.
  - Source id constants `SRC_INST = 1'b0`, `SRC_DATA = 1'b1`.
  - Sram-like size constants (byte = 0, half = 1, word = 2).
- Sub-module `req_order_fifo`: DEPTH × 1-bit synchronous FIFO with push, pop, head, full, empty and async active-low reset. The arbiter FSM, payload mux and starvation counter stay in the top.

## Test plan
- Single inst read:
  - Stimulus: `inst_req` at `addr=0x1c000000`, `mem_addr_ok` high the same cycle; 3 cycles later `mem_data_ok` with `mem_rdata=0x12345678`.
  - Response: `inst_addr_ok=1` same cycle; `inst_data_ok=1` with `inst_rdata=0x12345678`; `data_data_ok=0`.
- Simultaneous requests:
  - Stimulus: `inst_req=1`, `data_req=1` (`data_addr=0x80`, `wr=1`, `wstrb=0xF`), `mem_addr_ok=1`.
  - Response: `mem_addr=0x80`, `data_addr_ok=1`, `inst_addr_ok=0`. Inst is accepted the next cycle.
- Lock:
  - Stimulus: inst granted with `mem_addr_ok` low for 3 cycles; `data_req` rises in cycle 2.
  - Response: `mem_addr` stays at the inst address until accept; data is accepted the cycle after.
- Starvation:
  - Stimulus: `data_req` and `inst_req` held high, `mem_addr_ok=1`, STARVE_MAX=4.
  - Response: 4 data accepts, then 1 inst accept, then data resumes.
- FIFO full:
  - Stimulus: DEPTH=4; 4 accepts with no `data_ok`.
  - Response: `mem_req=0` while both request. One `mem_data_ok` pops the oldest entry to the correct requester; a grant resumes the next cycle.
- Reset mid-flight:
  - Stimulus: 2 outstanding, pulse `resetn` low asynchronously, then `mem_data_ok=1`.
  - Response: both `*_data_ok` stay 0 and the FIFO remains empty.
